protected_guard: RTL and testbench

PROTECTED_GUARD -- requirements
Module: protected_guard

---
 rtl/protected_guard_pkg.sv | 12 +
 rtl/protected_guard_cmp.sv | 12 +
 rtl/protected_guard.sv | 180 ++++++++++++++++++
 tb/tb_protected_guard.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/protected_guard_pkg.sv
// Shared FSM state type and default sizing for protected_guard.
package protected_guard_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DENY = 2'd2
   } state_t;

   localparam int CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/protected_guard_cmp.sv
// Unsigned address-below-boundary compare used by the protection check.
module protected_guard_cmp #(
   parameter int BUS_WIDTH = 32
) (
   input  logic [BUS_WIDTH-1:0] i_addr,
   input  logic [BUS_WIDTH-1:0] i_limit,
   output logic                 o_below
);

   assign o_below = (i_addr < i_limit);

endmodule

// File: rtl/protected_guard.sv
// Write-protection guard between a request port and memory; logs denied accesses.
// Optional build macro PROTECTED_GUARD_READ_BLOCK_EN extends denial to reads.
module protected_guard
   import protected_guard_pkg::*;
#(
   parameter int BUS_WIDTH = 32,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 protected_flag,
   input  logic [BUS_WIDTH-1:0] protected_addr,
   input  logic                 req_valid,
   input  logic                 req_write,
   output logic                 req_ready,
   input  logic [BUS_WIDTH-1:0] req_addr,
   input  logic [BUS_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic                 rsp_err,
   output logic [BUS_WIDTH-1:0] rsp_rdata,
   output logic                 mem_valid,
   output logic                 mem_write,
   input  logic                 mem_ready,
   output logic [BUS_WIDTH-1:0] mem_addr,
   output logic [BUS_WIDTH-1:0] mem_wdata,
   input  logic [BUS_WIDTH-1:0] mem_rdata,
   input  logic                 fault_clear,
   output logic                 fault,
   output logic [BUS_WIDTH-1:0] fault_addr,
   output logic [CNT_WIDTH-1:0] fault_count
);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_below;
   logic                   w_deny;
   logic                   w_accept;
   logic                   r_req_ready;
   logic                   r_mem_valid;
   logic                   r_mem_write;
   logic [BUS_WIDTH-1:0]   r_mem_addr;
   logic [BUS_WIDTH-1:0]   r_mem_wdata;
   logic                   r_rsp_valid;
   logic                   r_rsp_err;
   logic [BUS_WIDTH-1:0]   r_rsp_rdata;
   logic                   r_fault;
   logic [BUS_WIDTH-1:0]   r_fault_addr;
   logic [CNT_WIDTH-1:0]   r_fault_count;

   protected_guard_cmp #(
      .BUS_WIDTH (BUS_WIDTH)
   ) u_cmp (
      .i_addr  (req_addr),
      .i_limit (protected_addr),
      .o_below (w_below)
   );

`ifdef PROTECTED_GUARD_READ_BLOCK_EN
   assign w_deny = protected_flag & w_below;
`else
   assign w_deny = protected_flag & req_write & w_below;
`endif

   // req_ready is registered, so acceptance is gated by it rather than by the state alone
   assign w_accept = r_req_ready & req_valid;

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_deny ? DENY : FWD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         FWD: begin
            if (mem_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = FWD;
            end
         end
         DENY:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Request capture and downstream handshake
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_req_ready <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= {BUS_WIDTH{1'b0}};
         r_mem_wdata <= {BUS_WIDTH{1'b0}};
      end else begin
         r_req_ready <= (w_state_nxt == IDLE);
         r_mem_valid <= (w_state_nxt == FWD);
         if (w_accept) begin
            r_mem_write <= req_write;
            r_mem_addr  <= req_addr;
            r_mem_wdata <= req_wdata;
         end else begin
            r_mem_write <= r_mem_write;
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
         end
      end
   end

   // One-cycle response pulse
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= {BUS_WIDTH{1'b0}};
      end else if ((r_state == FWD) && mem_ready) begin
         r_rsp_valid <= 1'b1;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= mem_rdata;
      end else if (r_state == DENY) begin
         r_rsp_valid <= 1'b1;
         r_rsp_err   <= 1'b1;
         r_rsp_rdata <= {BUS_WIDTH{1'b0}};
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= r_rsp_rdata;
      end
   end

   // Fault log; a denial outranks a simultaneous clear
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_fault       <= 1'b0;
         r_fault_addr  <= {BUS_WIDTH{1'b0}};
         r_fault_count <= {CNT_WIDTH{1'b0}};
      end else if (w_accept && w_deny) begin
         r_fault      <= 1'b1;
         r_fault_addr <= req_addr;
         if (r_fault_count != {CNT_WIDTH{1'b1}}) begin
            r_fault_count <= r_fault_count + CNT_WIDTH'(1);
         end else begin
            r_fault_count <= r_fault_count;
         end
      end else if (fault_clear) begin
         r_fault       <= 1'b0;
         r_fault_addr  <= r_fault_addr;
         r_fault_count <= r_fault_count;
      end else begin
         r_fault       <= r_fault;
         r_fault_addr  <= r_fault_addr;
         r_fault_count <= r_fault_count;
      end
   end

   assign req_ready   = r_req_ready;
   assign mem_valid   = r_mem_valid;
   assign mem_write   = r_mem_write;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_err     = r_rsp_err;
   assign rsp_rdata   = r_rsp_rdata;
   assign fault       = r_fault;
   assign fault_addr  = r_fault_addr;
   assign fault_count = r_fault_count;

endmodule

// File: tb/tb_protected_guard.sv
// Directed, table-driven bench for protected_guard with hand-computed expectations.
module tb_protected_guard;

   localparam int BW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          nreset = 1'b0;
   logic          protected_flag = 1'b0;
   logic [BW-1:0] protected_addr = '0;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic          req_ready;
   logic [BW-1:0] req_addr = '0;
   logic [BW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_err;
   logic [BW-1:0] rsp_rdata;
   logic          mem_valid;
   logic          mem_write;
   logic          mem_ready = 1'b0;
   logic [BW-1:0] mem_addr;
   logic [BW-1:0] mem_wdata;
   logic [BW-1:0] mem_rdata = '0;
   logic          fault_clear = 1'b0;
   logic          fault;
   logic [BW-1:0] fault_addr;
   logic [CW-1:0] fault_count;

   int            errors = 0;
   int            checks = 0;
   logic          exp_fault = 1'b0;
   logic [BW-1:0] exp_faddr = '0;
   logic [CW-1:0] exp_count = '0;

   typedef struct {
      logic          flag;
      logic [BW-1:0] paddr;
      logic          wr;
      logic [BW-1:0] addr;
      logic [BW-1:0] wdata;
      int            waits;
      logic [BW-1:0] rdata;
      logic          deny;
      logic          deny_rb;
   } vec_t;

   vec_t vecs [8];

   protected_guard #(
      .BUS_WIDTH (BW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk            (clk),
      .nreset         (nreset),
      .protected_flag (protected_flag),
      .protected_addr (protected_addr),
      .req_valid      (req_valid),
      .req_write      (req_write),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_err        (rsp_err),
      .rsp_rdata      (rsp_rdata),
      .mem_valid      (mem_valid),
      .mem_write      (mem_write),
      .mem_ready      (mem_ready),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .fault_clear    (fault_clear),
      .fault          (fault),
      .fault_addr     (fault_addr),
      .fault_count    (fault_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_fault(input string name);
      chk1({name, ".fault"}, fault, exp_fault);
      chk({name, ".fault_addr"}, fault_addr, exp_faddr);
      chk({name, ".fault_count"}, {24'd0, fault_count}, {24'd0, exp_count});
   endtask

   // One complete request; protection inputs switch to mid_* right after acceptance
   task automatic run_req(input string name, input logic flag, input logic [BW-1:0] paddr,
                          input logic wr, input logic [BW-1:0] addr, input logic [BW-1:0] wdata,
                          input int waits, input logic [BW-1:0] rdata, input logic deny,
                          input logic clr, input logic mid_flag, input logic [BW-1:0] mid_paddr);
      chk1({name, ".ready_before"}, req_ready, 1'b1);
      protected_flag = flag;
      protected_addr = paddr;
      req_write      = wr;
      req_addr       = addr;
      req_wdata      = wdata;
      req_valid      = 1'b1;
      fault_clear    = clr;
      tick();
      req_valid      = 1'b0;
      fault_clear    = 1'b0;
      protected_flag = mid_flag;
      protected_addr = mid_paddr;
      if (deny) begin
         exp_fault = 1'b1;
         exp_faddr = addr;
         if (exp_count != 8'hFF) exp_count = exp_count + 8'd1;
      end else if (clr) begin
         exp_fault = 1'b0;
      end
      chk1({name, ".ready_busy"}, req_ready, 1'b0);
      chk_fault(name);
      if (deny) begin
         chk1({name, ".mem_valid_deny"}, mem_valid, 1'b0);
         chk1({name, ".rsp_early"}, rsp_valid, 1'b0);
         tick();
         chk1({name, ".rsp_valid"}, rsp_valid, 1'b1);
         chk1({name, ".rsp_err"}, rsp_err, 1'b1);
         chk({name, ".rsp_rdata"}, rsp_rdata, 32'd0);
         chk1({name, ".mem_valid_deny2"}, mem_valid, 1'b0);
      end else begin
         chk1({name, ".mem_valid"}, mem_valid, 1'b1);
         chk({name, ".mem_addr"}, mem_addr, addr);
         chk1({name, ".mem_write"}, mem_write, wr);
         chk({name, ".mem_wdata"}, mem_wdata, wdata);
         for (int w = 0; w < waits; w++) begin
            tick();
            chk1({name, ".mem_valid_hold"}, mem_valid, 1'b1);
            chk({name, ".mem_addr_hold"}, mem_addr, addr);
            chk1({name, ".rsp_wait"}, rsp_valid, 1'b0);
         end
         mem_ready = 1'b1;
         mem_rdata = rdata;
         tick();
         mem_ready = 1'b0;
         chk1({name, ".rsp_valid"}, rsp_valid, 1'b1);
         chk1({name, ".rsp_err"}, rsp_err, 1'b0);
         chk({name, ".rsp_rdata"}, rsp_rdata, rdata);
         chk1({name, ".mem_valid_drop"}, mem_valid, 1'b0);
      end
      chk1({name, ".ready_after"}, req_ready, 1'b1);
      tick();
      chk1({name, ".rsp_pulse"}, rsp_valid, 1'b0);
      chk_fault(name);
   endtask

   initial begin
      logic d;
      //          flag  paddr          wr    addr           wdata         wt rdata         deny  deny_rb
      vecs[0] = '{1'b0, 32'd0,         1'b1, 32'd1,         32'h0000_00A5, 2, 32'h1111_1111, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'd3,         1'b1, 32'd2,         32'h0000_0022, 0, 32'h0,         1'b1, 1'b1};
      vecs[2] = '{1'b1, 32'd3,         1'b1, 32'd3,         32'h0000_0033, 1, 32'h2222_2222, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'd3,         1'b0, 32'd0,         32'h0,         0, 32'h3333_3333, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 32'h4444_4444, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 32'hCAFE_F00D, 0, 32'h0,         1'b1, 1'b1};
      vecs[6] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h0000_0066, 3, 32'h5555_5555, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0200, 32'h0,         1, 32'h6666_6666, 1'b0, 1'b0};

      #12;
      chk1("reset.req_ready", req_ready, 1'b0);
      chk1("reset.mem_valid", mem_valid, 1'b0);
      chk1("reset.rsp_valid", rsp_valid, 1'b0);
      chk({"reset.mem_addr"}, mem_addr, 32'd0);
      chk_fault("reset");
      @(negedge clk);
      nreset = 1'b1;
      tick();
      chk1("reset.ready_release", req_ready, 1'b1);

      for (int i = 0; i < 8; i++) begin
`ifdef PROTECTED_GUARD_READ_BLOCK_EN
         d = vecs[i].deny_rb;
`else
         d = vecs[i].deny;
`endif
         run_req($sformatf("vec%0d", i), vecs[i].flag, vecs[i].paddr, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata, vecs[i].waits, vecs[i].rdata, d, 1'b0, vecs[i].flag, vecs[i].paddr);
      end

      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      exp_fault = 1'b0;
      chk_fault("clear_only");

      run_req("clr_vs_deny", 1'b1, 32'd3, 1'b1, 32'd1, 32'h77, 0, 32'h0, 1'b1, 1'b1, 1'b1, 32'd3);
      run_req("paddr_mid", 1'b1, 32'd3, 1'b1, 32'd3, 32'h88, 2, 32'h9999_0000, 1'b0, 1'b0, 1'b1, 32'd0);
      run_req("flag_mid", 1'b0, 32'h10, 1'b1, 32'h4, 32'h99, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h10);

      for (int i = 0; i < 256; i++) begin
         run_req("sat", 1'b1, 32'd3, 1'b1, 32'(i % 3), 32'(i), 0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd3);
      end
      chk({"sat.count"}, {24'd0, fault_count}, 32'd255);
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      exp_fault = 1'b0;
      chk_fault("sat_clear");
      chk({"sat_clear.count"}, {24'd0, fault_count}, 32'd255);

      protected_flag = 1'b0;
      req_write      = 1'b1;
      req_addr       = 32'h55;
      req_wdata      = 32'hAB;
      req_valid      = 1'b1;
      tick();
      req_valid = 1'b0;
      chk1("rst_fwd.mem_valid", mem_valid, 1'b1);
      #2;
      nreset = 1'b0;
      #1;
      exp_fault = 1'b0;
      exp_faddr = '0;
      exp_count = '0;
      chk1("rst_fwd.mem_valid_async", mem_valid, 1'b0);
      chk1("rst_fwd.rsp_valid", rsp_valid, 1'b0);
      chk1("rst_fwd.req_ready_in_reset", req_ready, 1'b0);
      chk_fault("rst_fwd");
      @(negedge clk);
      nreset    = 1'b1;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk1("rst_fwd.no_rsp", rsp_valid, 1'b0);
      chk1("rst_fwd.mem_valid_after", mem_valid, 1'b0);
      chk1("rst_fwd.req_ready_after", req_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
